// File: rtl/nn_weight_loader_if.sv
// nn_weight_loader_if: streaming beat input and packed layer write bus of the weight loader
interface nn_weight_loader_if #(
  parameter int IN_WIDTH    = 16,
  parameter int WRITE_WIDTH = 160,
  parameter int ADDR_WIDTH  = 10
);
  logic                   start;
  logic                   abort;
  logic                   in_valid;
  logic [IN_WIDTH-1:0]    in_data;
  logic                   in_ready;
  logic                   weight_write_enable;
  logic                   bias_write_enable;
  logic                   layer_write_select;
  logic [ADDR_WIDTH-1:0]  write_address_select;
  logic [WRITE_WIDTH-1:0] write_in;
  logic                   busy;
  logic                   load_done;
  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, weight_write_enable, bias_write_enable, layer_write_select,
           write_address_select, write_in, busy, load_done
  );
  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, weight_write_enable, bias_write_enable, layer_write_select,
           write_address_select, write_in, busy, load_done
  );
endinterface

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: packs narrow beats into wide words and writes L1 weights, L1 bias, L2 weights, L2 bias in order
module nn_weight_loader #(
  parameter int IN_WIDTH       = 16,
  parameter int WRITE_WIDTH    = 160,
  parameter int L1_WEIGHT_ROWS = 784,
  parameter int L2_WEIGHT_ROWS = 16,
  parameter int ADDR_WIDTH     = 10
) (
  input logic clk,
  input logic reset,
  nn_weight_loader_if.slave bus
);
  localparam int BEATS = WRITE_WIDTH / IN_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] L1_LAST = ADDR_WIDTH'(L1_WEIGHT_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] L2_LAST = ADDR_WIDTH'(L2_WEIGHT_ROWS - 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  // bit 0 marks a bias section, bit 1 selects Layer2
  typedef enum logic [1:0] {L1W, L1B, L2W, L2B} section_t;
  state_t                state;
  section_t              section;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BW-1:0]         beat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= IDLE;
      section                  <= L1W;
      addr                     <= '0;
      beat                     <= '0;
      bus.in_ready             <= 1'b0;
      bus.weight_write_enable  <= 1'b0;
      bus.bias_write_enable    <= 1'b0;
      bus.layer_write_select   <= 1'b0;
      bus.write_address_select <= '0;
      bus.write_in             <= '0;
      bus.busy                 <= 1'b0;
      bus.load_done            <= 1'b0;
    end else begin
      bus.weight_write_enable <= 1'b0;
      bus.bias_write_enable   <= 1'b0;
      if (bus.abort) begin
        state         <= IDLE;
        section       <= L1W;
        addr          <= '0;
        beat          <= '0;
        bus.in_ready  <= 1'b0;
        bus.busy      <= 1'b0;
        bus.load_done <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (bus.start) begin
            state         <= FILL;
            section       <= L1W;
            addr          <= '0;
            beat          <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b1;
            bus.load_done <= 1'b0;
          end
          FILL: if (bus.in_valid) begin
            for (int i = 0; i < BEATS; i++)
              if (beat == BW'(i)) bus.write_in[i*IN_WIDTH +: IN_WIDTH] <= bus.in_data;
            beat <= beat == LAST_BEAT ? '0 : beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state                    <= WRITE;
              bus.in_ready             <= 1'b0;
              bus.weight_write_enable  <= !section[0];
              bus.bias_write_enable    <= section[0];
              bus.layer_write_select   <= section[1];
              bus.write_address_select <= section[0] ? '0 : addr;
            end
          end
          WRITE: begin
            state         <= section == L2B ? DONE : FILL;
            bus.in_ready  <= section != L2B;
            bus.busy      <= section != L2B;
            bus.load_done <= section == L2B;
            if ((section == L1W && addr != L1_LAST) || (section == L2W && addr != L2_LAST))
              addr <= addr + 1'b1;
            else begin
              addr    <= '0;
              section <= section_t'(section + 2'd1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nn_weight_loader.sv
// tb_nn_weight_loader: directed loads against a scoreboard of expected layer writes
module tb_nn_weight_loader;
  localparam int IW = 8, WW = 24, AW = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  nn_weight_loader_if #(.IN_WIDTH(IW), .WRITE_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();
  nn_weight_loader #(
    .IN_WIDTH(IW), .WRITE_WIDTH(WW), .L1_WEIGHT_ROWS(4), .L2_WEIGHT_ROWS(2), .ADDR_WIDTH(AW)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct {
    logic          weight;
    logic          layer;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  int n_assert = 0, n_fail = 0, n_strobe = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    wr_t e;
    if (!reset && (bus.weight_write_enable || bus.bias_write_enable)) begin
      n_strobe++;
      chk("strobe_in_ready", bus.in_ready, 0);
      chk("strobe_busy", bus.busy, 1);
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed=strobe expected=none");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_weight", bus.weight_write_enable, e.weight);
        chk("wr_bias", bus.bias_write_enable, !e.weight);
        chk("wr_layer", bus.layer_write_select, e.layer);
        chk("wr_addr", bus.write_address_select, e.addr);
        chk("wr_data", bus.write_in, e.data);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_words(input int n);
    wr_t e;
    for (int w = 0; w < n; w++) begin
      e.weight = !(w == 4 || w == 7);
      e.layer  = w > 4;
      e.addr   = AW'(w < 4 ? w : (w == 5 || w == 6) ? w - 5 : 0);
      e.data   = {8'(3*w+3), 8'(3*w+2), 8'(3*w+1)};
      exp_q.push_back(e);
    end
  endtask
  task automatic send_beat(input logic [7:0] d, input int gap);
    bit acc = 0;
    int n = 0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("beat_accepted", acc, 1);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_weight_we"}, bus.weight_write_enable, 0);
    chk({tag, "_bias_we"}, bus.bias_write_enable, 0);
    chk({tag, "_layer"}, bus.layer_write_select, 0);
    chk({tag, "_addr"}, bus.write_address_select, 0);
    chk({tag, "_write_in"}, bus.write_in, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
  endtask
  task automatic run_load(input int gap, input bit hold_start);
    push_words(8);
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    chk("start_clears_done", bus.load_done, 0);
    chk("start_busy", bus.busy, 1);
    for (int w = 0; w < 8; w++) begin
      if (w == 7) bus.start = 1'b0;
      for (int k = 0; k < 3; k++) send_beat(8'(3*w+k+1), gap);
      @(negedge clk);
      chk("strobe_after_last_beat", bus.weight_write_enable | bus.bias_write_enable, 1);
    end
    @(negedge clk);
    chk("load_done", bus.load_done, 1);
    chk("done_busy", bus.busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    #2;
    check_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    // full load, continuous beats
    run_load(0, 0);
    // beats offered in DONE are refused, then reload from DONE
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_in_ready", bus.in_ready, 0);
      chk("done_hold", bus.load_done, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    run_load(0, 0);
    // stalled stream
    run_load(5, 0);
    // abort after 10 accepted beats
    s0 = n_strobe;
    push_words(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(8'(i+1), 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_load_done", bus.load_done, 0);
    chk("abort_write_in_held", bus.write_in, 24'h09080A);
    tick();
    chk("abort_strobes", n_strobe - s0, 3);
    chk("abort_queue", exp_q.size(), 0);
    run_load(0, 0);
    // asynchronous reset in the middle of a word
    push_words(1);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_beat(8'(i+1), 0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    chk("pre_reset_queue", exp_q.size(), 0);
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_idle", bus.busy, 0);
    run_load(0, 1);
    // start and abort together from IDLE
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    s0 = n_strobe;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("start_abort_busy", bus.busy, 0);
      chk("start_abort_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    chk("start_abort_strobes", n_strobe - s0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
